program_loader: RTL

Hardware boot loader for the SAP-2 computer: it receives a framed byte stream (from a UART receiver or a bench driver), writes the payload into the computer's RAM through its write port, and holds the CPU in reset until a complete, valid image is loaded. It replaces `$readmemh` preloading for on-board use and sits between the serial front end and `u_ram`. It is the writer for the program memory that the CPU executes.

---
 rtl/program_loader.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// ============================================================================
// program_loader : framed byte-stream boot loader for SAP-2 program RAM.
// Optional macro LOADER_CHECKSUM_EN adds a trailing checksum byte.
// Revision: 1.0
// ============================================================================
`default_nettype none

module program_loader #(
  parameter int         ADDR_WIDTH = 4,
  parameter int         DATA_WIDTH = 8,
  parameter logic [7:0] HEADER     = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  output logic                  cpu_reset_o,
  output logic                  load_done_o,
  output logic                  load_error_o
);

  localparam int          CW    = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_ADDR  = 3'd2,
    S_DATA  = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [CW-1:0]         remain;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  done_q;
  logic                  error_q;

  logic take;
  logic len_ok;
  logic last_byte;
  logic hdr_take;
  logic len_load;
  logic len_bad;
  logic ptr_load;
  logic data_take;
  logic set_done;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic       ck_bad;
  logic       enter_done;
`endif

  assign rx_ready_o   = (state != S_DONE);
  assign take         = rx_valid_i && rx_ready_o;
  assign len_ok       = (rx_data_i != 8'd0) && (32'(rx_data_i) <= DEPTH);
  assign last_byte    = (remain == CW'(1));
  assign load_done_o  = done_q;
  assign load_error_o = error_q;
  assign cpu_reset_o  = !done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    hdr_take   = 1'b0;
    len_load   = 1'b0;
    len_bad    = 1'b0;
    ptr_load   = 1'b0;
    data_take  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    ck_bad     = 1'b0;
    enter_done = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (take && rx_data_i == HEADER) begin
          hdr_take   = 1'b1;
          next_state = S_LEN;
        end
      end
      S_LEN: begin
        if (take) begin
          if (len_ok) begin
            len_load   = 1'b1;
            next_state = S_ADDR;
          end else begin
            len_bad    = 1'b1;
            next_state = S_IDLE;
          end
        end
      end
      S_ADDR: begin
        if (take) begin
          ptr_load   = 1'b1;
          next_state = S_DATA;
        end
      end
      S_DATA: begin
        if (take) begin
          data_take = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          if (last_byte) next_state = S_CHECK;
`else
          if (last_byte) next_state = S_DONE;
`endif
        end
      end
      S_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
        if (take) begin
          if (8'(sum + rx_data_i) == 8'd0) begin
            enter_done = 1'b1;
            next_state = S_DONE;
          end else begin
            ck_bad     = 1'b1;
            next_state = S_IDLE;
          end
        end
`else
        next_state = S_IDLE;
`endif
      end
      S_DONE:  next_state = S_DONE;
      default: next_state = S_IDLE;
    endcase
  end

  // Without a checksum, done is delayed a cycle so the final write lands first.
`ifdef LOADER_CHECKSUM_EN
  assign set_done = enter_done;
`else
  assign set_done = (state == S_DONE);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_we_o   <= 1'b0;
      ram_addr_o <= '0;
      ram_data_o <= '0;
      ptr        <= '0;
      remain     <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum        <= 8'd0;
`endif
    end else begin
      ram_we_o <= data_take;
      if (data_take) begin
        ram_addr_o <= ptr;
        ram_data_o <= DATA_WIDTH'(rx_data_i);
        ptr        <= ptr + 1'b1;
        remain     <= remain - 1'b1;
`ifdef LOADER_CHECKSUM_EN
        sum        <= sum + rx_data_i;
`endif
      end
      if (hdr_take) begin
        error_q <= 1'b0;
        remain  <= '0;
`ifdef LOADER_CHECKSUM_EN
        sum     <= 8'd0;
`endif
      end
      if (len_load) remain <= CW'(rx_data_i);
      if (ptr_load) ptr    <= ADDR_WIDTH'(rx_data_i);
`ifdef LOADER_CHECKSUM_EN
      if (len_bad || ck_bad) error_q <= 1'b1;
`else
      if (len_bad) error_q <= 1'b1;
`endif
      if (set_done) done_q <= 1'b1;
    end
  end

endmodule

`default_nettype wire
